// File: rtl/sdpram_row_reader_if.sv
// Valid/ready row stream from the sdpram row reader to the matrix datapath.
// The reader drives the master modport and the consumer drives the slave modport.
interface sdpram_row_reader_if #(
  parameter int DATA_W = 256
) ();
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/sdpram_row_reader.sv
// Streams row_count consecutive sdpram rows from base_addr through a 2-entry FIFO.
// Optional macro SDPRAM_READER_STALL_CNT_EN adds a saturating stall_cycles counter.
module sdpram_row_reader #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   row_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_q,
  sdpram_row_reader_if.master m
`ifdef SDPRAM_READER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   issue_left_q, issue_left_d;
  logic [ADDR_W:0]   beats_left_q, beats_left_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SDPRAM_READER_STALL_CNT_EN
  logic [15:0]       stall_q, stall_d;
`endif

  logic       pop;
  logic [2:0] occ;
  logic [1:0] wr_idx;

  // Occupancy counts the slot freed by a same-cycle pop, which is what keeps 1 row/cycle.
  assign pop = (count_q != 2'd0) && m.m_ready;
  assign occ = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};

  assign m.m_valid = (count_q != 2'd0);
  assign m.m_data  = buf_q[0];
  assign m.m_last  = (count_q != 2'd0) && (beats_left_q == CNT_ONE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_wen   = 1'b0;
`ifdef SDPRAM_READER_STALL_CNT_EN
  assign stall_cycles = stall_q;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beats_left_d = beats_left_q;
    inflight_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    buf_d        = buf_q;
    wr_idx       = count_q;
    count_d      = count_q + {1'b0, inflight_q} - {1'b0, pop};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (row_count != '0) begin
            state_d      = READ;
            addr_d       = base_addr;
            issue_left_d = row_count;
            beats_left_d = row_count;
            busy_d       = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        // The RAM samples addr_q at this edge; count it as a read only when space is assured.
        if (occ < 3'd2) begin
          inflight_d   = 1'b1;
          addr_d       = (addr_q == ADDR_TOP) ? '0 : addr_q + ADDR_ONE;
          issue_left_d = issue_left_q - CNT_ONE;
          if (issue_left_q == CNT_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && beats_left_q == CNT_ONE) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      buf_d[0]     = buf_q[1];
      wr_idx       = count_q - 2'd1;
      beats_left_d = beats_left_q - CNT_ONE;
    end
    if (inflight_q) buf_d[wr_idx[0]] = mem_q;
  end

`ifdef SDPRAM_READER_STALL_CNT_EN
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (m.m_valid && !m.m_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      // NOTE: the two buffer rows are reset only because m_data must read 0 out of reset.
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
`ifdef SDPRAM_READER_STALL_CNT_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      buf_q[0]     <= buf_d[0];
      buf_q[1]     <= buf_d[1];
`ifdef SDPRAM_READER_STALL_CNT_EN
      stall_q      <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdpram_row_reader.sv
// Scoreboard bench for sdpram_row_reader: directed commands push expected rows,
// a negedge monitor pops and compares every accepted beat.
module tb_sdpram_row_reader;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4:0]    base_addr;
  logic [5:0]    row_count;
  logic          busy, done, mem_wen;
  logic [4:0]    mem_addr;
  logic [DW-1:0] mem_q;
`ifdef SDPRAM_READER_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  sdpram_row_reader_if #(.DATA_W(DW)) s_if ();

  sdpram_row_reader #(.DATA_W(DW), .ADDR_W(5), .DEPTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .row_count (row_count),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_q     (mem_q),
    .m         (s_if)
`ifdef SDPRAM_READER_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: address sampled at edge N, data valid after it.
  logic [DW-1:0] ram [32];
  always @(posedge clk) mem_q <= ram[mem_addr];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            vectors = 0;
  int            miscompares = 0;
  int            ready_mode = 0;
  logic [7:0]    pat;
  logic          track_ahead = 1'b0;
  logic [4:0]    track_base;
  logic [4:0]    ahead;
  int            accepted = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  // Called at #1 after an edge; start is sampled at the next edge E, returns at #1 after E.
  task automatic issue_start(input logic [4:0] b, input logic [5:0] c);
    start     = 1'b1;
    base_addr = b;
    row_count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_n, input int n0, input string name);
    int n;
    n = n0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " done_seen"}, done, 1'b1);
    if (exp_n >= 0) check({name, " done_cycle"}, n, exp_n);
    check({name, " busy_at_done"}, busy, 1'b0);
    check({name, " rows_outstanding"}, sb.size(), 0);
    @(posedge clk);
    #1;
    check({name, " done_pulse_width"}, done, 1'b0);
  endtask

  // Monitor: checks hold-during-stall, read-ahead bound, and every accepted beat.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", s_if.m_valid, 1'b1);
        check("hold_data", s_if.m_data, prev_data);
      end
      if (track_ahead) begin
        ahead = mem_addr - track_base - accepted[4:0];
        check("addr_ahead_le_2", (ahead <= 5'd2), 1'b1);
      end
      if (s_if.m_valid && s_if.m_ready) begin
        accepted++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", s_if.m_data);
        end else begin
          mon_e = sb.pop_front();
          check("beat_data", s_if.m_data, mon_e.data);
          check("beat_last", s_if.m_last, mon_e.last);
        end
      end
      prev_stall = s_if.m_valid && !s_if.m_ready;
      prev_data  = s_if.m_data;
    end
  end

  // Ready pattern driver, active only in toggle mode.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        s_if.m_ready = pat[0];
        pat = {pat[0], pat[7:1]};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_count = '0;
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 32; i++) ram[i] = {8{32'(32'h5000_0000 + i)}};
    ram[1] = DW'(1337);
    ram[2] = DW'(1338);
    ram[3] = DW'(2022);
    ram[4] = DW'(2023);

    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst m_valid", s_if.m_valid, 1'b0);
    check("rst m_last", s_if.m_last, 1'b0);
    check("rst m_data", s_if.m_data, '0);
    check("rst mem_addr", mem_addr, 5'd0);
    check("rst mem_wen", mem_wen, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Four rows at full throughput, with latency checks.
    push_exp(DW'(1337), 1'b0);
    push_exp(DW'(1338), 1'b0);
    push_exp(DW'(2022), 1'b0);
    push_exp(DW'(2023), 1'b1);
    issue_start(5'd1, 6'd4);
    check("t1 mem_addr_after_start", mem_addr, 5'd1);
    check("t1 busy", busy, 1'b1);
    check("t1 valid_e0", s_if.m_valid, 1'b0);
    @(posedge clk);
    #1;
    check("t1 valid_e1", s_if.m_valid, 1'b0);
    @(posedge clk);
    #1;
    check("t1 valid_e2", s_if.m_valid, 1'b1);
    wait_done(6, 2, "t1");

    // Same command under a toggling ready.
    push_exp(DW'(1337), 1'b0);
    push_exp(DW'(1338), 1'b0);
    push_exp(DW'(2022), 1'b0);
    push_exp(DW'(2023), 1'b1);
    pat = 8'b0110_1001;
    ready_mode = 1;
    issue_start(5'd1, 6'd4);
    track_base = 5'd1;
    accepted = 0;
    track_ahead = 1'b1;
    wait_done(-1, 0, "t2");
    track_ahead = 1'b0;
    ready_mode = 0;
    s_if.m_ready = 1'b1;

    // Wrap-around 30, 31, 0, 1.
    ram[30] = DW'(256'hA);
    ram[31] = DW'(256'hB);
    ram[0]  = DW'(256'hC);
    ram[1]  = DW'(256'hD);
    push_exp(DW'(256'hA), 1'b0);
    push_exp(DW'(256'hB), 1'b0);
    push_exp(DW'(256'hC), 1'b0);
    push_exp(DW'(256'hD), 1'b1);
    issue_start(5'd30, 6'd4);
    wait_done(6, 0, "wrap");

    // Zero-length command.
    issue_start(5'd7, 6'd0);
    wait_done(0, 0, "zero");
    for (int i = 0; i < 3; i++) begin
      check("zero no_valid", s_if.m_valid, 1'b0);
      @(posedge clk);
      #1;
    end

    // Full-depth command starting at row 5.
    for (int i = 0; i < 32; i++) push_exp(ram[(5 + i) % 32], (i == 31));
    issue_start(5'd5, 6'd32);
    wait_done(34, 0, "full");

    // Reset after two beats of a four-row command.
    push_exp(ram[10], 1'b0);
    push_exp(ram[11], 1'b0);
    issue_start(5'd10, 6'd4);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    s_if.m_ready = 1'b0;
    @(posedge clk);
    #1;
    check("abort m_valid", s_if.m_valid, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort beats_seen", sb.size(), 0);
    rst = 1'b0;
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort no_done", done, 1'b0);
    end
    push_exp(DW'(2022), 1'b1);
    issue_start(5'd3, 6'd1);
    wait_done(3, 0, "after_rst");

`ifdef SDPRAM_READER_STALL_CNT_EN
    // Five stalled cycles, then a fresh start clears the counter.
    push_exp(DW'(1338), 1'b1);
    s_if.m_ready = 1'b0;
    issue_start(5'd2, 6'd1);
    begin
      int n;
      n = 0;
      while (!s_if.m_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("stall valid_seen", s_if.m_valid, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    s_if.m_ready = 1'b1;
    wait_done(-1, 0, "stall");
    check("stall count", stall_cycles, 16'd5);
    issue_start(5'd0, 6'd0);
    check("stall cleared", stall_cycles, 16'd0);
    wait_done(0, 0, "stall_clear");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
